// File: rtl/btn_cnt_pkg.sv
// Shared constants and types for the push-button up/down counter.
package btn_cnt_pkg;

    // Consecutive equal tick samples needed before a button's debounced state changes
    localparam int DEB_SAMPLES       = 3;
    // Auto-repeat timing in sample ticks: delay to the first repeat, then the repeat period
    localparam int REPEAT_DLY_TICKS  = 100;
    localparam int REPEAT_RATE_TICKS = 20;
    // Repeat counter width; it must hold REPEAT_DLY_TICKS-1
    localparam int REP_CNT_W         = 7;
    // Default sample period: 5 ms at 50 MHz
    localparam int DEB_DIV_DEFAULT   = 250000;

    // Action the counter performs in a given cycle
    typedef enum logic [1:0] {
        CMD_IDLE = 2'd0,
        CMD_UP   = 2'd1,
        CMD_DOWN = 2'd2,
        CMD_CLR  = 2'd3
    } cnt_cmd_t;

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: a 2-flop synchronizer, a tick-sampled history,
// the debounced level and a single-cycle press-event pulse.
// Optional auto-repeat while held is built only when BTN_AUTOREPEAT_EN is defined.
module btn_debounce
    import btn_cnt_pkg::*;
(
    input  logic CLK,
    input  logic RSTn,
    input  logic i_btn_n,   // raw button, active-low, asynchronous to CLK
    input  logic i_tick,    // shared sample tick
    output logic o_press    // one-cycle press event
);

    logic [1:0]             r_sync;
    logic [DEB_SAMPLES-1:0] r_hist;
    logic                   r_deb_n;    // debounced level, 1 = released
    logic                   r_press;
    logic [DEB_SAMPLES-1:0] w_hist_next;
    logic                   w_to_pressed;
    logic                   w_to_released;
    logic                   w_rep_fire;

    // The newest sample joins the history on the same tick it is judged
    assign w_hist_next   = {r_hist[DEB_SAMPLES-2:0], r_sync[1]};
    assign w_to_pressed  = i_tick &&  r_deb_n && (w_hist_next == '0);
    assign w_to_released = i_tick && !r_deb_n && (w_hist_next == '1);

    // Two-flop synchronizer; idles at the released level
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) r_sync <= 2'b11;
        else       r_sync <= {r_sync[0], i_btn_n};
    end

    // Shift one synchronized sample into the history per tick
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)       r_hist <= '1;
        else if (i_tick) r_hist <= w_hist_next;
    end

    // Debounced level follows the history once all samples agree on the opposite level
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)              r_deb_n <= 1'b1;
        else if (w_to_pressed)  r_deb_n <= 1'b0;
        else if (w_to_released) r_deb_n <= 1'b1;
    end

`ifdef BTN_AUTOREPEAT_EN
    logic [REP_CNT_W-1:0] r_rep_cnt;
    logic                 r_rep_armed;  // first repeat already issued
    logic                 w_rep_hit;

    assign w_rep_hit  = r_rep_armed ? (r_rep_cnt == REP_CNT_W'(REPEAT_RATE_TICKS - 1))
                                    : (r_rep_cnt == REP_CNT_W'(REPEAT_DLY_TICKS - 1));
    // Never repeat on the tick that debounces the release
    assign w_rep_fire = i_tick && !r_deb_n && !w_to_released && w_rep_hit;

    // Count ticks of continuous pressed state; restart whenever the button is released
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
        end else if (r_deb_n) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
        end else if (i_tick) begin
            if (w_rep_fire) begin
                r_rep_cnt   <= '0;
                r_rep_armed <= 1'b1;
            end else begin
                r_rep_cnt   <= r_rep_cnt + REP_CNT_W'(1);
            end
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    // Press event is registered, so it is high in the first cycle the button reads pressed
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) r_press <= 1'b0;
        else       r_press <= w_to_pressed | w_rep_fire;
    end

    assign o_press = r_press;

endmodule

// File: rtl/btn_updown_cnt8.sv
// 8-bit up/down counter driven by two debounced push-buttons, with a
// synchronous clear, optional saturation, and change/wrap pulses for the
// display stage. Auto-repeat is enabled by defining BTN_AUTOREPEAT_EN.
module btn_updown_cnt8
    import btn_cnt_pkg::*;
#(
    parameter int DEB_DIV  = DEB_DIV_DEFAULT,
    parameter bit SATURATE = 1'b0
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       UPn,
    input  logic       DOWNn,
    input  logic       CLR,
    output logic [7:0] BIN,
    output logic       CHG,
    output logic       WRAP
);

    localparam int PW = $clog2(DEB_DIV);

    logic [PW-1:0] r_presc;
    logic          w_tick;
    logic [1:0]    w_btn_n;   // [0] = up, [1] = down
    logic [1:0]    w_press;
    cnt_cmd_t      w_cmd;
    logic [7:0]    r_bin;
    logic          r_chg;
    logic          r_wrap;

    assign w_tick  = (r_presc == PW'(DEB_DIV - 1));
    assign w_btn_n = {DOWNn, UPn};

    // Free-running sample prescaler shared by both buttons
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)       r_presc <= '0;
        else if (w_tick) r_presc <= '0;
        else             r_presc <= r_presc + PW'(1);
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            btn_debounce u_deb (
                .CLK     (CLK),
                .RSTn    (RSTn),
                .i_btn_n (w_btn_n[gi]),
                .i_tick  (w_tick),
                .o_press (w_press[gi])
            );
        end
    endgenerate

    // Clear wins over events; simultaneous up and down cancel each other
    always_comb begin
        w_cmd = CMD_IDLE;
        if (CLR)                         w_cmd = CMD_CLR;
        else if (w_press[0] && !w_press[1]) w_cmd = CMD_UP;
        else if (w_press[1] && !w_press[0]) w_cmd = CMD_DOWN;
    end

    // Counter update; CHG and WRAP describe the value just written and last one cycle
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_bin  <= 8'd0;
            r_chg  <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_chg  <= 1'b0;
            r_wrap <= 1'b0;
            case (w_cmd)
                CMD_CLR: begin
                    r_bin <= 8'd0;
                    r_chg <= (r_bin != 8'd0);
                end
                CMD_UP: begin
                    if (!(SATURATE && r_bin == 8'hFF)) begin
                        r_bin  <= r_bin + 8'd1;
                        r_chg  <= 1'b1;
                        r_wrap <= (r_bin == 8'hFF);
                    end
                end
                CMD_DOWN: begin
                    if (!(SATURATE && r_bin == 8'h00)) begin
                        r_bin  <= r_bin - 8'd1;
                        r_chg  <= 1'b1;
                        r_wrap <= (r_bin == 8'h00);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign BIN  = r_bin;
    assign CHG  = r_chg;
    assign WRAP = r_wrap;

endmodule

// File: tb/tb_btn_updown_cnt8.sv
// Testbench for btn_updown_cnt8 with DEB_DIV=4: a wrapping instance checked
// through a CHG-driven scoreboard, and a saturating instance checked by pulse counts.
module tb_btn_updown_cnt8;

    localparam int DIV = 4;

    typedef struct packed {
        logic [7:0] bin;
        logic       wrap;
    } exp_t;

    logic       CLK   = 1'b0;
    logic       RSTn  = 1'b0;
    logic       UPn   = 1'b1;
    logic       DOWNn = 1'b1;
    logic       CLR   = 1'b0;
    logic [7:0] BIN;
    logic       CHG;
    logic       WRAP;

    logic       s_upn = 1'b1;
    logic       s_dnn = 1'b1;
    logic       s_clr = 1'b0;
    logic [7:0] s_bin;
    logic       s_chg;
    logic       s_wrap;

    int   checks = 0;
    int   errors = 0;
    int   cyc;
    int   s_chg_cnt  = 0;
    int   s_wrap_cnt = 0;
    exp_t sb_q[$];
    logic [7:0] exp_bin = 8'd0;

    btn_updown_cnt8 #(.DEB_DIV(DIV), .SATURATE(1'b0)) u_dut (
        .CLK(CLK), .RSTn(RSTn), .UPn(UPn), .DOWNn(DOWNn), .CLR(CLR),
        .BIN(BIN), .CHG(CHG), .WRAP(WRAP)
    );

    btn_updown_cnt8 #(.DEB_DIV(DIV), .SATURATE(1'b1)) u_dut_sat (
        .CLK(CLK), .RSTn(RSTn), .UPn(s_upn), .DOWNn(s_dnn), .CLR(s_clr),
        .BIN(s_bin), .CHG(s_chg), .WRAP(s_wrap)
    );

    always #5 CLK = ~CLK;

    // Cycle count since reset release; sample ticks land on edges where cyc becomes a multiple of DIV
    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Scoreboard: every CHG pulse must match the oldest pending expectation
    always @(negedge CLK) begin : mon
        exp_t e;
        if (RSTn) begin
            if (WRAP && !CHG) begin
                checks++; errors++;
                $display("FAIL wrap_without_chg: WRAP=1 CHG=0 BIN=%0d", BIN);
            end
            if (CHG) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_chg: BIN=%0d WRAP=%0d, none expected", BIN, WRAP);
                end else begin
                    e = sb_q.pop_front();
                    if (BIN !== e.bin || WRAP !== e.wrap) begin
                        errors++;
                        $display("FAIL chg_value: BIN=%0d WRAP=%0d, expected BIN=%0d WRAP=%0d",
                                 BIN, WRAP, e.bin, e.wrap);
                    end else begin
                        $display("chg ok: BIN=%0d WRAP=%0d", BIN, WRAP);
                    end
                end
            end
            if (s_chg)  s_chg_cnt++;
            if (s_wrap) s_wrap_cnt++;
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n * DIV) @(negedge CLK);
    endtask

    task automatic push_up();
        exp_t e;
        e.bin  = exp_bin + 8'd1;
        e.wrap = (exp_bin == 8'hFF);
        sb_q.push_back(e);
        exp_bin = e.bin;
    endtask

    task automatic push_down();
        exp_t e;
        e.bin  = exp_bin - 8'd1;
        e.wrap = (exp_bin == 8'h00);
        sb_q.push_back(e);
        exp_bin = e.bin;
    endtask

    task automatic push_clr();
        exp_t e;
        e.bin  = 8'd0;
        e.wrap = 1'b0;
        sb_q.push_back(e);
        exp_bin = 8'd0;
    endtask

    // One clean press of the wrapping instance: 4 ticks held, 5 ticks released
    task automatic press(input logic up, input logic dn);
        @(negedge CLK);
        UPn   = ~up;
        DOWNn = ~dn;
        wait_ticks(4);
        UPn   = 1'b1;
        DOWNn = 1'b1;
        wait_ticks(5);
    endtask

    task automatic press_s(input logic up, input logic dn);
        @(negedge CLK);
        s_upn = ~up;
        s_dnn = ~dn;
        wait_ticks(4);
        s_upn = 1'b1;
        s_dnn = 1'b1;
        wait_ticks(4);
    endtask

    // Bounded wait for all pending expectations to be consumed
    task automatic drain(input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected CHG pulses missing", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic check_bin(input string name);
        checks++;
        if (BIN !== exp_bin) begin
            errors++;
            $display("FAIL %s: BIN=%0d, expected %0d", name, BIN, exp_bin);
        end else begin
            $display("%s: BIN=%0d", name, BIN);
        end
    endtask

    task automatic test_reset();
        UPn = 1'b0;   // held through reset release for the next scenario
        repeat (3) @(negedge CLK);
        #1;
        checks++;
        if (BIN !== 8'd0)  begin errors++; $display("FAIL reset_bin: BIN=%0d, expected 0", BIN); end
        checks++;
        if (CHG !== 1'b0)  begin errors++; $display("FAIL reset_chg: CHG=%0b, expected 0", CHG); end
        checks++;
        if (WRAP !== 1'b0) begin errors++; $display("FAIL reset_wrap: WRAP=%0b, expected 0", WRAP); end
        $display("reset: BIN=%0d CHG=%0b WRAP=%0b", BIN, CHG, WRAP);
    endtask

    task automatic test_hold_through_reset();
        @(negedge CLK);
        RSTn = 1'b1;
        push_up();
        wait_ticks(20);
        UPn = 1'b1;
        wait_ticks(6);
        drain("hold_20");
        check_bin("hold_20");
    endtask

    task automatic test_glitch();
        @(negedge CLK);
        UPn = 1'b0;
        repeat (2 * DIV) @(negedge CLK);
        UPn = 1'b1;
        wait_ticks(6);
        check_bin("glitch");
    endtask

    task automatic test_wrap();
        push_down(); press(1'b0, 1'b1); drain("down_to_0");    check_bin("down_to_0");
        push_down(); press(1'b0, 1'b1); drain("down_wrap");    check_bin("down_wrap");
        push_up();   press(1'b1, 1'b0); drain("up_wrap");      check_bin("up_wrap");
        push_down(); press(1'b0, 1'b1); drain("down_wrap2");   check_bin("down_wrap2");
    endtask

    task automatic test_both();
        press(1'b1, 1'b1);
        drain("both");
        check_bin("both_cancel");
    endtask

    task automatic test_clr_event();
        for (int i = 0; i < 8; i++) begin
            push_up();
            press(1'b1, 1'b0);
        end
        drain("count_to_7");
        check_bin("count_to_7");
        // Align to the start of a tick period so the press event cycle is known
        @(negedge CLK);
        while (cyc % DIV != 0) @(negedge CLK);
        UPn = 1'b0;
        repeat (12) @(negedge CLK);
        push_clr();
        CLR = 1'b1;
        repeat (2) @(negedge CLK);
        CLR = 1'b0;
        wait_ticks(2);
        UPn = 1'b1;
        wait_ticks(6);
        drain("clr_vs_up");
        check_bin("clr_vs_up");
        // Clearing an already-zero count produces no CHG
        @(negedge CLK);
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        wait_ticks(2);
        check_bin("clr_at_0");
    endtask

    task automatic test_reset_mid_debounce();
        push_up(); press(1'b1, 1'b0); drain("pre_mid"); check_bin("pre_mid");
        @(negedge CLK);
        UPn = 1'b0;
        wait_ticks(2);
        RSTn = 1'b0;
        #1;
        exp_bin = 8'd0;
        sb_q.delete();
        check_bin("async_reset");
        repeat (3) @(negedge CLK);
        RSTn = 1'b1;
        wait_ticks(1);
        UPn = 1'b1;
        wait_ticks(6);
        check_bin("mid_debounce_discard");
    endtask

    task automatic test_autorepeat();
        int n_events;
`ifdef BTN_AUTOREPEAT_EN
        n_events = 4;
`else
        n_events = 1;
`endif
        for (int i = 0; i < n_events; i++) push_up();
        @(negedge CLK);
        UPn = 1'b0;
        wait_ticks(3 + 100 + 50);   // released between the third and fourth repeat
        UPn = 1'b1;
        wait_ticks(6);
        drain("autorepeat");
        check_bin("autorepeat");
    endtask

    task automatic test_saturate();
        s_chg_cnt  = 0;
        s_wrap_cnt = 0;
        press_s(1'b0, 1'b1);
        checks++;
        if (s_bin !== 8'd0 || s_chg_cnt != 0) begin
            errors++;
            $display("FAIL sat_down_at_0: BIN=%0d CHG pulses=%0d, expected 0 and 0", s_bin, s_chg_cnt);
        end else $display("sat_down_at_0: BIN=%0d", s_bin);
        for (int i = 0; i < 255; i++) press_s(1'b1, 1'b0);
        checks++;
        if (s_bin !== 8'd255 || s_chg_cnt != 255) begin
            errors++;
            $display("FAIL sat_count_up: BIN=%0d CHG pulses=%0d, expected 255 and 255", s_bin, s_chg_cnt);
        end else $display("sat_count_up: BIN=%0d", s_bin);
        press_s(1'b1, 1'b0);
        checks++;
        if (s_bin !== 8'd255 || s_chg_cnt != 255) begin
            errors++;
            $display("FAIL sat_up_at_255: BIN=%0d CHG pulses=%0d, expected 255 and 255", s_bin, s_chg_cnt);
        end else $display("sat_up_at_255: BIN=%0d", s_bin);
        checks++;
        if (s_wrap_cnt != 0) begin
            errors++;
            $display("FAIL sat_no_wrap: WRAP pulses=%0d, expected 0", s_wrap_cnt);
        end else $display("sat_no_wrap: WRAP pulses=0");
    endtask

    initial begin
        test_reset();
        test_hold_through_reset();
        test_glitch();
        test_wrap();
        test_both();
        test_clr_event();
        test_reset_mid_debounce();
        test_autorepeat();
        test_saturate();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d expectations pending", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
